// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM states, BCD digits,
// the packed MM:SS.cc display word and the ripple-carry BCD increment.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    typedef logic [3:0]  bcd_t;
    typedef logic [23:0] disp_t;

    localparam bcd_t  DIGIT_MAX_9 = 4'd9;
    localparam bcd_t  DIGIT_MAX_5 = 4'd5;
    localparam disp_t MAX_COUNT   = 24'h595999;

    // Digit order from LSB: cs_o, cs_t, sec_o, sec_t, min_o, min_t.
    // A digit at or above its limit rolls to 0 and carries on.
    // As a result, a corrupted digit also returns to a legal value.
    function automatic disp_t bcd_inc(input disp_t c);
        disp_t r;
        logic  carry;
        bcd_t  d;
        bcd_t  lim;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d   = c[i*4 +: 4];
            lim = (i == 3 || i == 5) ? DIGIT_MAX_5 : DIGIT_MAX_9;
            if (carry) begin
                if (d >= lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ enabled cycles.
// The count is held while the enable is low, so partial intervals survive a pause.
module tick_gen #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core. It contains the start/stop/lap/clear FSM, the saturating
// BCD MM:SS.cc counter and the registered display mux. All outputs are registered.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        ovf,
    output state_t      state_dbg
);

    state_t state_q, state_d;
    disp_t  count_q, count_d;
    disp_t  lap_q, lap_d;
    disp_t  disp_q, disp_d;
    logic   ovf_q, ovf_d;
    logic   running_q, running_d;
    logic   lap_active_q, lap_active_d;
    logic   tick;
    logic   presc_clr;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .en    (running_q),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lap_d     = lap_q;
        ovf_d     = ovf_q;
        presc_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                if (start_stop) begin
                    state_d = PAUSE;
                end else if (lap) begin
                    lap_d   = count_q;
                    state_d = LAP;
                end
            end
            LAP: begin
                if (start_stop) state_d = PAUSE;
                else if (lap)   state_d = RUN;
            end
            PAUSE: begin
                // After a saturation, clear is the only way out.
                if (clear) begin
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    presc_clr = 1'b1;
                    state_d   = IDLE;
                end else if (start_stop && !ovf_q) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // A tick occurs only in RUN or LAP, so it never collides with a clear.
        if (tick) begin
            if (count_q == MAX_COUNT) begin
                ovf_d   = 1'b1;
                state_d = PAUSE;
            end else begin
                count_d = bcd_inc(count_q);
            end
        end
    end

    assign running_d    = (state_d == RUN) || (state_d == LAP);
    assign lap_active_d = (state_d == LAP);
    assign disp_d       = (state_q == LAP) ? lap_q : count_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            lap_q        <= '0;
            disp_q       <= '0;
            ovf_q        <= 1'b0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
            ovf_q        <= ovf_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign disp_bcd   = disp_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign ovf        = ovf_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV = 10. Inputs change 1 time unit after a
// rising edge, and outputs are sampled at that same point.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        ovf;
    state_t      state_dbg;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .disp_bcd  (disp_bcd),
        .running   (running),
        .lap_active(lap_active),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        step(1);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    initial begin
        #23;
        chk("rst_disp", disp_bcd, 24'h0);
        chk("rst_running", running, 1'b0);
        rst_n = 1'b1;
        step(1);

        // Idle with no inputs.
        step(50);
        chk("idle_disp", disp_bcd, 24'h0);
        chk("idle_running", running, 1'b0);
        chk("idle_ovf", ovf, 1'b0);
        chk("idle_lap_active", lap_active, 1'b0);
        chk("idle_state", state_dbg, IDLE);
        pulse(1'b0, 1'b1, 1'b1);
        chk("idle_ignore_state", state_dbg, IDLE);
        chk("idle_ignore_lap", lap_active, 1'b0);

        // The start is sampled at edge N.
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_running", running, 1'b1);
        chk("start_state", state_dbg, RUN);
        step(9);
        chk("n9_count", dut.count_q, 24'h000000);
        step(1);
        chk("n10_count", dut.count_q, 24'h000001);
        step(1);
        chk("n11_disp", disp_bcd, 24'h000001);
        step(990);
        chk("n1001_disp", disp_bcd, 24'h000100);

        // A clear in RUN is ignored.
        pulse(1'b0, 1'b0, 1'b1);
        chk("run_clear_state", state_dbg, RUN);
        chk("run_clear_count", dut.count_q, 24'h000100);
        pulse(1'b1, 1'b0, 1'b0);
        chk("pause_state", state_dbg, PAUSE);
        chk("pause_presc", dut.u_tick.cnt_q, 4'd3);
        step(2);
        chk("pause_presc_hold", dut.u_tick.cnt_q, 4'd3);
        chk("pause_count_hold", dut.count_q, 24'h000100);
        pulse(1'b0, 1'b0, 1'b1);
        chk("clear_state", state_dbg, IDLE);
        chk("clear_count", dut.count_q, 24'h0);
        chk("clear_presc", dut.u_tick.cnt_q, 4'd0);
        step(1);
        chk("clear_disp", disp_bcd, 24'h0);

        // Lap freeze. The start is at edge S, and the lap is sampled at S+555.
        pulse(1'b1, 1'b0, 1'b0);
        step(554);
        pulse(1'b0, 1'b1, 1'b0);
        chk("lap_active", lap_active, 1'b1);
        chk("lap_state", state_dbg, LAP);
        step(1);
        chk("lap_disp", disp_bcd, 24'h000055);
        step(20);
        chk("lap_disp_frozen", disp_bcd, 24'h000055);
        chk("lap_count_live", dut.count_q, 24'h000057);
        chk("lap_active_hold", lap_active, 1'b1);
        step(8);
        pulse(1'b0, 1'b1, 1'b0);
        chk("lap2_active", lap_active, 1'b0);
        chk("lap2_state", state_dbg, RUN);
        step(1);
        chk("lap2_disp", disp_bcd, 24'h000058);

        // Pause with the prescaler at 4. The next increment is 6 cycles after resume.
        step(7);
        pulse(1'b1, 1'b0, 1'b0);
        chk("p4_state", state_dbg, PAUSE);
        chk("p4_running", running, 1'b0);
        chk("p4_presc", dut.u_tick.cnt_q, 4'd4);
        step(3);
        chk("p4_presc_hold", dut.u_tick.cnt_q, 4'd4);
        chk("p4_count_hold", dut.count_q, 24'h000059);
        pulse(1'b1, 1'b0, 1'b0);
        chk("resume_running", running, 1'b1);
        step(5);
        chk("resume_r5_count", dut.count_q, 24'h000059);
        step(1);
        chk("resume_r6_count", dut.count_q, 24'h000060);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        chk("clr_prio_state", state_dbg, IDLE);
        chk("clr_prio_count", dut.count_q, 24'h0);
        step(1);
        chk("clr_prio_disp", disp_bcd, 24'h0);
        chk("clr_prio_running", running, 1'b0);

        // Full ripple carry, and start_stop has priority over lap in RUN.
        dut.count_q = 24'h095999;
        pulse(1'b1, 1'b0, 1'b0);
        step(10);
        chk("ripple_count", dut.count_q, 24'h100000);
        pulse(1'b1, 1'b1, 1'b0);
        chk("ss_prio_state", state_dbg, PAUSE);
        chk("ss_prio_lap", lap_active, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("ripple_clear", dut.count_q, 24'h0);

        // Saturation at 59:59.99.
        dut.count_q = 24'h595998;
        pulse(1'b1, 1'b0, 1'b0);
        step(10);
        chk("sat_pre_count", dut.count_q, 24'h595999);
        chk("sat_pre_ovf", ovf, 1'b0);
        step(10);
        chk("sat_ovf", ovf, 1'b1);
        chk("sat_state", state_dbg, PAUSE);
        chk("sat_running", running, 1'b0);
        chk("sat_count", dut.count_q, 24'h595999);
        step(1);
        chk("sat_disp", disp_bcd, 24'h595999);
        pulse(1'b1, 1'b0, 1'b0);
        chk("sat_ss_state", state_dbg, PAUSE);
        chk("sat_ss_ovf", ovf, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("sat_clear_ovf", ovf, 1'b0);
        chk("sat_clear_count", dut.count_q, 24'h0);
        chk("sat_clear_state", state_dbg, IDLE);
        step(1);
        chk("sat_clear_disp", disp_bcd, 24'h0);

        // Reset asserted mid-LAP, between clock edges.
        pulse(1'b1, 1'b0, 1'b0);
        step(37);
        pulse(1'b0, 1'b1, 1'b0);
        step(3);
        chk("pre_rst_disp", disp_bcd, 24'h000003);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_disp", disp_bcd, 24'h0);
        chk("arst_running", running, 1'b0);
        chk("arst_lap_active", lap_active, 1'b0);
        chk("arst_ovf", ovf, 1'b0);
        chk("arst_state", state_dbg, IDLE);
        #2 rst_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
